// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, one-outstanding imem handshake and IF/ID register.
// Latency: 1 cycle from imem response to IF/ID; back-to-back issue gives 1 instr/cycle.
// Backpressure: pc_enab/enab_FD stall parks a returned instruction in a hold buffer, no drops.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_enab,
    input  logic        enab_FD,
    input  logic        branch_taken_D,
    input  logic [31:0] branch_target_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_plus4_D,
    output logic        valid_D,
    output logic [4:0]  rs_D,
    output logic [4:0]  rt_D,
    output logic        fetch_bubble
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // request pending, not yet accepted
        S_WAIT = 2'd1,   // request accepted, response outstanding
        S_HOLD = 2'd2    // response parked while decode is stalled
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_f;
    logic [31:0] pc_nxt;
    logic        kill;
    logic        kill_nxt;
    logic [31:0] hold_buf;
    logic [31:0] hold_buf_nxt;
    logic        issue;

    logic        redirect;
    logic        avail;
    logic        consume;
    logic [31:0] load_word;

    // Branches are only honoured when the pipeline is moving.
    assign redirect  = branch_taken_D & enab_FD & pc_enab;
    assign avail     = ((state == S_WAIT) & imem_rvalid & ~kill) | (state == S_HOLD);
    assign consume   = avail & pc_enab & enab_FD & ~redirect;
    assign load_word = (state == S_HOLD) ? hold_buf : imem_rdata;

    assign fetch_bubble = enab_FD & ~redirect & ~avail;
    assign rs_D         = instr_D[25:21];
    assign rt_D         = instr_D[20:16];

    // Next-state, next-PC and request generation.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_f;
        kill_nxt     = kill;
        hold_buf_nxt = hold_buf;
        imem_req     = 1'b0;
        imem_addr    = pc_f;
        issue        = 1'b0;
        case (state)
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_f;
                if (redirect) begin
                    pc_nxt = branch_target_D;
                end
                if (imem_ack) begin
                    state_nxt = S_WAIT;
                    // The accepted address is the pre-redirect PC, so its data is stale.
                    kill_nxt  = redirect;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    kill_nxt = 1'b0;
                    if (redirect) begin
                        pc_nxt = branch_target_D;
                        issue  = 1'b1;
                    end else if (kill) begin
                        issue  = 1'b1;
                    end else if (consume) begin
                        pc_nxt = pc_f + 32'd4;
                        issue  = 1'b1;
                    end else begin
                        hold_buf_nxt = imem_rdata;
                        state_nxt    = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_nxt = 1'b1;
                    pc_nxt   = branch_target_D;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nxt = branch_target_D;
                    issue  = 1'b1;
                end else if (consume) begin
                    pc_nxt = pc_f + 32'd4;
                    issue  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
        // Issue the next fetch in the same cycle so a 1-cycle memory streams.
        if (issue) begin
            imem_req  = 1'b1;
            imem_addr = pc_nxt;
            state_nxt = imem_ack ? S_WAIT : S_REQ;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            pc_f     <= RESET_PC;
            kill     <= 1'b0;
            hold_buf <= NOP_INSTR;
        end else begin
            state    <= state_nxt;
            pc_f     <= pc_nxt;
            kill     <= kill_nxt;
            hold_buf <= hold_buf_nxt;
        end
    end

    // IF/ID register: redirect bubble, load, starvation bubble, or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_D    <= NOP_INSTR;
            pc_plus4_D <= 32'd0;
            valid_D    <= 1'b0;
        end else if (redirect) begin
            instr_D    <= NOP_INSTR;
            pc_plus4_D <= 32'd0;
            valid_D    <= 1'b0;
        end else if (consume) begin
            instr_D    <= load_word;
            pc_plus4_D <= pc_f + 32'd4;
            valid_D    <= 1'b1;
        end else if (enab_FD & ~avail) begin
            instr_D    <= NOP_INSTR;
            pc_plus4_D <= 32'd0;
            valid_D    <= 1'b0;
        end
    end

endmodule
